// File: rtl/vga_pkg.sv
// vga_pkg: shared frame geometry, slideshow size and fetch state encoding
package vga_pkg;
  localparam int WORDS_PER_LINE = 20;
  localparam int LINES = 480;
  localparam int WORDS_PER_FRAME = WORDS_PER_LINE * LINES;
  localparam int PICT_NUM = 6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;
endpackage

// File: rtl/vga_word_fifo.sv
// vga_word_fifo: show-ahead pixel-word FIFO with push/pop/flush and occupancy count
// Ports: clk, rst (async, active-high), push_i/data_i write, pop_i read,
//        flush_i empties, data_o head word, count_o occupancy, empty_o
module vga_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      wr_q <= push_i ? wr_q + AW'(1) : wr_q;
      rd_q <= pop_i ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
endmodule

// File: rtl/vga_fetch_ctrl.sv
// vga_fetch_ctrl: prefetches frame-buffer words for the VGA timing generator and rotates pictures
// Ports: frame_start/pict_adv control pulses, word_req/word_data/word_valid to the timing
//        generator, mem_rd_* read port (valid/ready request, in-order data return),
//        pict_idx current picture, underflow sticky flag.
// Option: VGA_FETCH_UNDERFLOW_EN enables underflow detection and the all-ones blank word.
module vga_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
  parameter int LINES = vga_pkg::LINES,
  parameter int PICT_NUM = vga_pkg::PICT_NUM,
  parameter int ADDR_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pict_adv,
  input  logic              word_req,
  output logic [31:0]       word_data,
  output logic              word_valid,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_dv,
  input  logic [31:0]       mem_rd_data,
  output logic [2:0]        pict_idx,
  output logic              underflow
);
  localparam int WPF = WORDS_PER_LINE * LINES;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, base_q, base_d, pbase_q, pbase_d;
  logic [2:0] pidx_q, pidx_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt;
  logic [CW:0] inflight;
  logic grant, push, pop, flush, empty, last_pict;
  logic [31:0] head;
  vga_word_fifo #(.DEPTH(FIFO_DEPTH), .W(32), .CW(CW)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .data_i(mem_rd_data), .pop_i(pop),
    .flush_i(flush), .data_o(head), .count_o(cnt), .empty_o(empty)
  );
  // Queued plus in-flight words never exceed the FIFO, so every returning beat has a slot.
  assign inflight = {1'b0, cnt} + {1'b0, out_q};
  assign mem_rd_req = state_q == RUN && inflight < (CW+1)'(FIFO_DEPTH) && ptr_q < ADDR_W'(WPF);
  assign mem_rd_addr = base_q + ptr_q;
  assign grant = mem_rd_req && mem_rd_gnt;
  assign flush = frame_start && (state_q == RUN || out_q != '0);
  assign push = mem_rd_dv && drop_q == '0 && !flush;
  assign pop = word_req && !empty;
  assign word_valid = !empty;
  assign pict_idx = pidx_q;
  assign last_pict = pidx_q == 3'(PICT_NUM - 1);
  always_comb begin
    pidx_d = pict_adv ? (last_pict ? 3'd0 : pidx_q + 3'd1) : pidx_q;
    pbase_d = pict_adv ? (last_pict ? '0 : pbase_q + ADDR_W'(WPF)) : pbase_q;
    out_d = out_q + CW'(grant) - CW'(mem_rd_dv);
    // Every read still in flight at a restart belongs to the old frame.
    drop_d = frame_start ? out_d : (mem_rd_dv && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    ptr_d = frame_start ? '0 : grant ? ptr_q + ADDR_W'(1) : ptr_q;
    base_d = frame_start ? pbase_d : base_q;
    state_d = frame_start ? RUN : (grant && ptr_q == ADDR_W'(WPF - 1)) ? DONE : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      base_q <= '0;
      pbase_q <= '0;
      pidx_q <= '0;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      base_q <= base_d;
      pbase_q <= pbase_d;
      pidx_q <= pidx_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
`ifdef VGA_FETCH_UNDERFLOW_EN
  logic uf_q, blank_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      uf_q <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      uf_q <= uf_q | (word_req & empty);
      blank_q <= push ? 1'b0 : (blank_q | (word_req & empty));
    end
  assign underflow = uf_q;
  assign word_data = blank_q ? 32'hFFFF_FFFF : head;
`else
  assign underflow = 1'b0;
  assign word_data = head;
`endif
endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// tb_vga_fetch_ctrl: randomized scoreboard bench for vga_fetch_ctrl with an in-order memory model
module tb_vga_fetch_ctrl;
  import vga_pkg::*;
  localparam int WPF = WORDS_PER_FRAME;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, frame_start = 0, pict_adv = 0, word_req = 0;
  logic mem_rd_gnt = 0, mem_rd_dv = 0;
  logic [31:0] mem_rd_data = 0, word_data;
  logic word_valid, mem_rd_req, underflow;
  logic [15:0] mem_rd_addr;
  logic [2:0] pict_idx;
  always #5 clk = ~clk;
  vga_fetch_ctrl #(.ADDR_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pict_adv(pict_adv),
    .word_req(word_req), .word_data(word_data), .word_valid(word_valid),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_dv(mem_rd_dv), .mem_rd_data(mem_rd_data), .pict_idx(pict_idx),
    .underflow(underflow)
  );
  typedef struct {logic [15:0] addr; int due;} rd_t;
  rd_t pend[$];
  logic [31:0] exp_q[$];
  int cyc = 0, last_due = 0, due;
  int gnt_pct = 0, req_pct = 0, lat_min = 2, lat_max = 2;
  bit fs_pulse = 0, adv_pulse = 0, req_pulse = 0;
  int n_checks = 0, n_err = 0;
  int m_idx = 0, m_ptr = 0, grants = 0, pops = 0;
  logic [15:0] m_base = 0, first_addr = 0, prev_addr = 0;
  logic [31:0] first_word = 0, e;
  bit first_pend = 0, fw_pend = 0, prev_req = 0, prev_gnt = 0, prev_fs = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  // Stimulus driver and in-order memory with randomized latency.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    mem_rd_gnt = $urandom_range(99, 0) < gnt_pct;
    word_req = req_pulse || ($urandom_range(99, 0) < req_pct);
    frame_start = fs_pulse;
    pict_adv = adv_pulse;
    {req_pulse, fs_pulse, adv_pulse} = 3'b000;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rd_dv = 1;
      mem_rd_data = 32'(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      mem_rd_dv = 0;
      mem_rd_data = $urandom;
    end
  end
  // Monitor: address order, request stability, scoreboard on every consumed word.
  always @(negedge clk) if (!rst) begin
    if (prev_req && !prev_gnt && !prev_fs) begin
      chk("req_hold", mem_rd_req, 1);
      chk("addr_hold", mem_rd_addr, prev_addr);
    end
    if (mem_rd_req && mem_rd_gnt) begin
      chk("rd_addr", mem_rd_addr, 32'(m_base) + m_ptr);
      chk("addr_in_frame", m_ptr < WPF, 1);
      if (first_pend) first_addr = mem_rd_addr;
      first_pend = 0;
      m_ptr++;
      grants++;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{mem_rd_addr, due});
    end
    if (word_req && word_valid) begin
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("word_data", word_data, e);
      end
      if (fw_pend) first_word = word_data;
      fw_pend = 0;
      pops++;
    end
    if (pict_adv) m_idx = (m_idx + 1) % PICT_NUM;
    if (frame_start) begin
      m_base = 16'(m_idx * WPF);
      m_ptr = 0;
      exp_q.delete();
      for (int k = 0; k < WPF; k++) exp_q.push_back(32'(m_base) + k);
      first_pend = 1;
      fw_pend = 1;
    end
    prev_req = mem_rd_req;
    prev_gnt = mem_rd_gnt;
    prev_fs = frame_start;
    prev_addr = mem_rd_addr;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1);
  end
  initial begin
    int g0, p0, t0;
    tick(3);
    rst = 0;
    tick();
    chk("rst_word_valid", word_valid, 0);
    chk("rst_word_data", word_data, 0);
    chk("rst_req", mem_rd_req, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_pict_idx", pict_idx, 0);
    chk("rst_underflow", underflow, 0);
    req_pulse = 1;
    tick(2);
`ifdef VGA_FETCH_UNDERFLOW_EN
    chk("underflow_set", underflow, 1);
    chk("underflow_blank", word_data, 32'hFFFF_FFFF);
`else
    chk("underflow_off", underflow, 0);
    chk("empty_req_data", word_data, 0);
`endif
    chk("idle_no_req", mem_rd_req, 0);
    // Full frame, memory granting every cycle, fixed 2-cycle latency.
    gnt_pct = 100;
    req_pct = 100;
    g0 = grants;
    p0 = pops;
    fs_pulse = 1;
    tick(2);
    chk("req_after_fs", mem_rd_req, 1);
    t0 = cyc;
    while (pops - p0 < WPF && cyc - t0 < 20000) tick();
    chk("frame_pops", pops - p0, WPF);
    chk("frame_throughput", (cyc - t0) <= WPF + 8, 1);
    chk("frame_grants", grants - g0, WPF);
    tick(5);
    chk("done_no_req", mem_rd_req, 0);
    chk("frame_drained", exp_q.size(), 0);
    // Prefetch bound with no consumer.
    req_pct = 0;
    g0 = grants;
    fs_pulse = 1;
    tick(100);
    chk("bound_grants", grants - g0, DEPTH);
    chk("bound_req_low", mem_rd_req, 0);
    g0 = grants;
    req_pulse = 1;
    tick(20);
    chk("refill_grants", grants - g0, 1);
    chk("refill_req_low", mem_rd_req, 0);
    // Slideshow rotation.
    req_pct = 100;
    for (int i = 0; i < PICT_NUM; i++) begin
      adv_pulse = 1;
      tick(2);
      fs_pulse = 1;
      tick();
      for (int n = 0; n < 20 && first_pend; n++) tick();
      chk("pict_first_seen", first_pend, 0);
      chk("pict_first_addr", first_addr, ((i + 1) % PICT_NUM) * WPF);
      chk("pict_idx", pict_idx, (i + 1) % PICT_NUM);
      tick(5);
    end
    adv_pulse = 1;
    fs_pulse = 1;
    tick();
    for (int n = 0; n < 20 && first_pend; n++) tick();
    chk("adv_fs_same_addr", first_addr, WPF);
    chk("adv_fs_same_idx", pict_idx, 1);
    // Restart with three reads outstanding; their beats must be discarded.
    gnt_pct = 0;
    req_pct = 0;
    tick(10);
    lat_min = 4;
    lat_max = 4;
    fs_pulse = 1;
    tick();
    gnt_pct = 100;
    for (int n = 0; n < 50 && pend.size() != 3; n++) tick();
    gnt_pct = 0;
    chk("pend_three", pend.size(), 3);
    adv_pulse = 1;
    fs_pulse = 1;
    tick();
    gnt_pct = 100;
    req_pct = 100;
    for (int n = 0; n < 40 && fw_pend; n++) tick();
    chk("drop_first_seen", fw_pend, 0);
    chk("drop_first_word", first_word, 2 * WPF);
    // Grant withheld: request and address must hold.
    lat_min = 1;
    lat_max = 3;
    req_pct = 0;
    gnt_pct = 0;
    fs_pulse = 1;
    tick(11);
    chk("stall_req", mem_rd_req, 1);
    chk("stall_addr", mem_rd_addr, 2 * WPF);
    gnt_pct = 100;
    req_pct = 50;
    tick(30);
    // Randomized traffic with occasional restarts and picture changes.
    gnt_pct = 70;
    req_pct = 60;
    lat_max = 4;
    repeat (3000) begin
      if ($urandom_range(299, 0) == 0) fs_pulse = 1;
      if ($urandom_range(199, 0) == 0) adv_pulse = 1;
      tick();
    end
    chk("random_pict_idx", pict_idx, m_idx);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
